// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle CPU: a Moore machine that decodes the IR
// opcode and drives the datapath strobes for each step of an instruction.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       PCWrite,
  output logic       PCWriteIfZero,
  output logic       PCWriteIfNonZero,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REX    = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_BNE    = 4'd10,
    S_AEX    = 4'd11,
    S_AWB    = 4'd12,
    S_JMP    = 4'd13,
    S_ILL    = 4'd14
  } state_t;

  state_t state, state_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational logic below uses blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave
    // a signal unassigned and infer a latch.
    state_next       = S_FETCH;
    PCWrite          = 1'b0;
    PCWriteIfZero    = 1'b0;
    PCWriteIfNonZero = 1'b0;
    IorD             = 1'b0;
    MemRead          = 1'b0;
    MemWrite         = 1'b0;
    IRWrite          = 1'b0;
    MemtoReg         = 1'b0;
    RegDst           = 1'b0;
    RegWrite         = 1'b0;
    ALUSrcA          = 1'b0;
    ALUSrcB          = 2'b00;
    ALUOp            = 2'b00;
    PCSource         = 2'b00;
    illegal_op       = 1'b0;

    unique case (state)
      S_INIT: ;
      S_FETCH: begin
        MemRead    = 1'b1;
        IRWrite    = 1'b1;
        ALUSrcB    = 2'b01;
        PCWrite    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_REX;
          OP_BEQ:       state_next = S_BEQ;
          OP_BNE:       state_next = S_BNE;
          OP_ADDI:      state_next = S_AEX;
          OP_J:         state_next = S_JMP;
          default:      state_next = S_ILL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        // Only lw/sw reach here and IR holds op, so anything but lw is a store.
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        state_next = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        PCSource      = 2'b01;
        PCWriteIfZero = 1'b1;
      end
      S_BNE: begin
        ALUSrcA          = 1'b1;
        ALUOp            = 2'b01;
        PCSource         = 2'b01;
        PCWriteIfNonZero = 1'b1;
      end
      S_AEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = S_AWB;
      end
      S_AWB:   RegWrite = 1'b1;
      S_JMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_ILL:   illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule
